// File: rtl/decode_stage_hs_pkg.sv
// Shared types and constants for the pentaRV decode-to-execute stage.
// Holds parameter defaults, control-word field offsets and the ID/EX update selector.
package decode_stage_hs_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int REGW_DEF   = 5;
    localparam int CTRL_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    // Control-word field offsets (produced upstream, carried opaquely here)
    localparam int CTRL_REGWRITE   = 0;
    localparam int CTRL_MEMWRITE   = 1;
    localparam int CTRL_ALUSRC     = 2;
    localparam int CTRL_RESSRC_LSB = 3;
    localparam int CTRL_BRANCH     = 5;
    localparam int CTRL_JUMP       = 6;
    localparam int CTRL_ALUCTL_LSB = 7;

    // Every bubble field is filled with this value
    localparam logic BUBBLE_FILL = 1'b0;

    typedef enum logic [2:0] {
        UPD_RESET,
        UPD_FLUSH,
        UPD_HOLD,
        UPD_LDUSE,
        UPD_IDLE,
        UPD_LOAD
    } idex_upd_e;

endpackage

// File: rtl/decode_stage_hs_regfile_bypass.sv
// Architectural register file: two combinational read ports, one write port,
// x0 hardwired to zero, write-first bypass from the write-back port.
module regfile_bypass #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int REGW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [REGW-1:0] i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [REGW-1:0] i_raddr1,
    input  logic [REGW-1:0] i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr;

    assign w_wr = i_we && (i_waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wr) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Write-first: a same-cycle write-back wins over the stored value
    always_comb begin
        o_rdata1 = r_regs[i_raddr1];
        o_rdata2 = r_regs[i_raddr2];
        if (w_wr && (i_waddr == i_raddr1)) o_rdata1 = i_wdata;
        if (w_wr && (i_waddr == i_raddr2)) o_rdata2 = i_wdata;
        if (i_raddr1 == '0) o_rdata1 = '0;
        if (i_raddr2 == '0) o_rdata2 = '0;
    end

endmodule

// File: rtl/decode_stage_hs.sv
// pentaRV decode-to-execute stage: register file read with bypass, load-use
// detection and the ID/EX register with handshake, stall hold and flush.
module decode_stage_hs
    import decode_stage_hs_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int REGW   = REGW_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_d,
    output logic              ready_d,
    input  logic [31:0]       instr_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   pcplus4_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [XLEN-1:0]   imm_d,
    input  logic              is_load_d,
    input  logic              use_rs1_d,
    input  logic              use_rs2_d,
    input  logic              ready_e,
    input  logic              flush_e,
    input  logic              RegWriteW,
    input  logic [REGW-1:0]   rdW,
    input  logic [XLEN-1:0]   resultW,
    output logic              valid_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [XLEN-1:0]   imm_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   pcplus4_e,
    output logic [XLEN-1:0]   r1_e,
    output logic [XLEN-1:0]   r2_e,
    output logic [REGW-1:0]   rd_e,
    output logic [REGW-1:0]   rs1_e,
    output logic [REGW-1:0]   rs2_e,
    output logic              is_load_e,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [REGW-1:0]   w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0]   w_rdata1, w_rdata2;
    logic              w_load_use, w_wb_hit1, w_wb_hit2, w_unused;
    idex_upd_e         w_upd;

    logic              r_valid_e, r_is_load_e;
    logic [CTRL_W-1:0] r_ctrl_e;
    logic [XLEN-1:0]   r_imm_e, r_pc_e, r_pcplus4_e, r_r1_e, r_r2_e;
    logic [REGW-1:0]   r_rd_e, r_rs1_e, r_rs2_e;
    logic [CNT_W-1:0]  r_bubble_cnt;

    assign w_rs1    = REGW'(instr_d[19:15]);
    assign w_rs2    = REGW'(instr_d[24:20]);
    assign w_rd     = REGW'(instr_d[11:7]);
    assign w_unused = ^{instr_d[31:25], instr_d[14:12], instr_d[6:0]};

    regfile_bypass #(.XLEN(XLEN), .NREGS(NREGS), .REGW(REGW)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .i_we     (RegWriteW),
        .i_waddr  (rdW),
        .i_wdata  (resultW),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2)
    );

    assign w_load_use = r_valid_e && r_is_load_e && (r_rd_e != '0) && valid_d &&
                        ((use_rs1_d && (w_rs1 == r_rd_e)) || (use_rs2_d && (w_rs2 == r_rd_e)));
    assign ready_d    = flush_e || (ready_e && !w_load_use);

    // Operands held in ID/EX must track write-backs that land during a stall
    assign w_wb_hit1 = RegWriteW && (rdW != '0) && (rdW == r_rs1_e);
    assign w_wb_hit2 = RegWriteW && (rdW != '0) && (rdW == r_rs2_e);

    always_comb begin
        w_upd = UPD_LOAD;
        if (rst)             w_upd = UPD_RESET;
        else if (flush_e)    w_upd = UPD_FLUSH;
        else if (!ready_e)   w_upd = UPD_HOLD;
        else if (w_load_use) w_upd = UPD_LDUSE;
        else if (!valid_d)   w_upd = UPD_IDLE;
    end

    always_ff @(posedge clk) begin
        case (w_upd)
            UPD_LOAD: begin
                r_valid_e   <= 1'b1;
                r_ctrl_e    <= ctrl_d;
                r_imm_e     <= imm_d;
                r_pc_e      <= pc_d;
                r_pcplus4_e <= pcplus4_d;
                r_r1_e      <= w_rdata1;
                r_r2_e      <= w_rdata2;
                r_rd_e      <= w_rd;
                r_rs1_e     <= w_rs1;
                r_rs2_e     <= w_rs2;
                r_is_load_e <= is_load_d;
            end
            UPD_HOLD: begin
                if (r_valid_e && w_wb_hit1) r_r1_e <= resultW;
                if (r_valid_e && w_wb_hit2) r_r2_e <= resultW;
            end
            default: begin
                r_valid_e   <= BUBBLE_FILL;
                r_ctrl_e    <= {CTRL_W{BUBBLE_FILL}};
                r_imm_e     <= {XLEN{BUBBLE_FILL}};
                r_pc_e      <= {XLEN{BUBBLE_FILL}};
                r_pcplus4_e <= {XLEN{BUBBLE_FILL}};
                r_r1_e      <= {XLEN{BUBBLE_FILL}};
                r_r2_e      <= {XLEN{BUBBLE_FILL}};
                r_rd_e      <= {REGW{BUBBLE_FILL}};
                r_rs1_e     <= {REGW{BUBBLE_FILL}};
                r_rs2_e     <= {REGW{BUBBLE_FILL}};
                r_is_load_e <= BUBBLE_FILL;
            end
        endcase

        if (w_upd == UPD_RESET)
            r_bubble_cnt <= '0;
        else if (((w_upd == UPD_FLUSH) || (w_upd == UPD_LDUSE)) && (r_bubble_cnt != '1))
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end

    assign valid_e    = r_valid_e;
    assign ctrl_e     = r_ctrl_e;
    assign imm_e      = r_imm_e;
    assign pc_e       = r_pc_e;
    assign pcplus4_e  = r_pcplus4_e;
    assign r1_e       = r_r1_e;
    assign r2_e       = r_r2_e;
    assign rd_e       = r_rd_e;
    assign rs1_e      = r_rs1_e;
    assign rs2_e      = r_rs2_e;
    assign is_load_e  = r_is_load_e;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Scoreboard bench for decode_stage_hs: issued instructions queue their expected
// ID/EX record; a monitor compares whenever EX accepts a valid ID/EX entry.
module tb_decode_stage_hs;

    typedef struct packed {
        logic [15:0] ctrl;
        logic [31:0] imm, pc, pc4, r1, r2;
        logic [4:0]  rd, rs1, rs2;
        logic        ld;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst, valid_d, ready_d, is_load_d, use_rs1_d, use_rs2_d;
    logic        ready_e, flush_e, RegWriteW, valid_e, is_load_e;
    logic [31:0] instr_d, pc_d, pcplus4_d, imm_d, resultW;
    logic [31:0] imm_e, pc_e, pcplus4_e, r1_e, r2_e;
    logic [15:0] ctrl_d, ctrl_e;
    logic [4:0]  rdW, rd_e, rs1_e, rs2_e;
    logic [1:0]  bubble_cnt;

    int   checks = 0;
    int   failures = 0;
    rec_t sb_q[$];

    always #5 clk = ~clk;

    decode_stage_hs #(.XLEN(32), .NREGS(32), .REGW(5), .CTRL_W(16), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .ready_d(ready_d), .instr_d(instr_d),
        .pc_d(pc_d), .pcplus4_d(pcplus4_d), .ctrl_d(ctrl_d), .imm_d(imm_d),
        .is_load_d(is_load_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
        .ready_e(ready_e), .flush_e(flush_e), .RegWriteW(RegWriteW), .rdW(rdW),
        .resultW(resultW), .valid_e(valid_e), .ctrl_e(ctrl_e), .imm_e(imm_e),
        .pc_e(pc_e), .pcplus4_e(pcplus4_e), .r1_e(r1_e), .r2_e(r2_e), .rd_e(rd_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .is_load_e(is_load_e), .bubble_cnt(bubble_cnt)
    );

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, 7'h33};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic present(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] pc, input logic [15:0] ctrl, input logic [31:0] imm,
                           input logic ld, input logic u1, input logic u2);
        valid_d   = 1'b1;
        instr_d   = mk(rd, rs1, rs2);
        pc_d      = pc;
        pcplus4_d = pc + 32'd4;
        ctrl_d    = ctrl;
        imm_d     = imm;
        is_load_d = ld;
        use_rs1_d = u1;
        use_rs2_d = u2;
    endtask

    task automatic expect_rec(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] pc, input logic [15:0] ctrl, input logic [31:0] imm,
                              input logic ld, input logic [31:0] r1, input logic [31:0] r2);
        rec_t e;
        e.ctrl = ctrl; e.imm = imm; e.pc = pc; e.pc4 = pc + 32'd4;
        e.r1 = r1; e.r2 = r2; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.ld = ld;
        sb_q.push_back(e);
    endtask

    task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
        RegWriteW = en;
        rdW       = rd;
        resultW   = data;
    endtask

    // Monitor: an ID/EX entry leaves the stage when valid_e && ready_e at the edge
    always @(negedge clk) begin
        rec_t a, e;
        if (!rst && valid_e && ready_e) begin
            a = '{ctrl: ctrl_e, imm: imm_e, pc: pc_e, pc4: pcplus4_e, r1: r1_e, r2: r2_e,
                  rd: rd_e, rs1: rs1_e, rs2: rs2_e, ld: is_load_e};
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL idex_unexpected actual pc=%h rd=%0d required none", pc_e, rd_e);
            end else begin
                e = sb_q.pop_front();
                if (a !== e) begin
                    failures++;
                    $display("FAIL idex_record actual=%h required=%h", a, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; valid_d = 1'b0; instr_d = '0; pc_d = '0; pcplus4_d = '0; ctrl_d = '0;
        imm_d = '0; is_load_d = 1'b0; use_rs1_d = 1'b0; use_rs2_d = 1'b0;
        ready_e = 1'b1; flush_e = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        tick(); tick();
        rst = 1'b0;
        chk("reset_valid_e", {31'b0, valid_e}, 32'd0);
        chk("reset_r1_e", r1_e, 32'd0);
        chk("reset_ctrl_e", {16'b0, ctrl_e}, 32'd0);
        chk("reset_bubble_cnt", {30'b0, bubble_cnt}, 32'd0);
        chk("reset_ready_d", {31'b0, ready_d}, 32'd1);

        // Write-back x5, then read it
        wb(1'b1, 5'd5, 32'h1234);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        present(5'd10, 5'd5, 5'd0, 32'h100, 16'h0011, 32'h20, 1'b0, 1'b1, 1'b0);
        expect_rec(5'd10, 5'd5, 5'd0, 32'h100, 16'h0011, 32'h20, 1'b0, 32'h1234, 32'd0);
        tick();
        chk("issue_valid_e", {31'b0, valid_e}, 32'd1);
        chk("issue_rd_e", {27'b0, rd_e}, 32'd10);

        // Same-cycle bypass on rs2
        wb(1'b1, 5'd7, 32'hA5A5A5A5);
        present(5'd11, 5'd0, 5'd7, 32'h104, 16'h0022, 32'h4, 1'b0, 1'b0, 1'b1);
        expect_rec(5'd11, 5'd0, 5'd7, 32'h104, 16'h0022, 32'h4, 1'b0, 32'd0, 32'hA5A5A5A5);
        tick();
        // Write to x0 in the same cycle x0 is read
        wb(1'b1, 5'd0, 32'hFFFFFFFF);
        present(5'd12, 5'd0, 5'd7, 32'h108, 16'h0033, 32'h8, 1'b0, 1'b1, 1'b1);
        expect_rec(5'd12, 5'd0, 5'd7, 32'h108, 16'h0033, 32'h8, 1'b0, 32'd0, 32'hA5A5A5A5);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        present(5'd13, 5'd0, 5'd0, 32'h10C, 16'h0044, 32'hC, 1'b0, 1'b1, 1'b1);
        expect_rec(5'd13, 5'd0, 5'd0, 32'h10C, 16'h0044, 32'hC, 1'b0, 32'd0, 32'd0);
        tick();

        // Load-use with a write-back of the load's rd on the bubble edge
        present(5'd3, 5'd5, 5'd0, 32'h110, 16'h0105, 32'h0, 1'b1, 1'b1, 1'b0);
        expect_rec(5'd3, 5'd5, 5'd0, 32'h110, 16'h0105, 32'h0, 1'b1, 32'h1234, 32'd0);
        tick();
        present(5'd14, 5'd3, 5'd0, 32'h114, 16'h0055, 32'h14, 1'b0, 1'b1, 1'b0);
        wb(1'b1, 5'd3, 32'h77);
        #1;
        chk("lduse_ready_d", {31'b0, ready_d}, 32'd0);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        chk("lduse_valid_e", {31'b0, valid_e}, 32'd0);
        chk("lduse_ctrl_e", {16'b0, ctrl_e}, 32'd0);
        chk("lduse_bubble_cnt", {30'b0, bubble_cnt}, 32'd1);
        chk("lduse_ready_d_after", {31'b0, ready_d}, 32'd1);
        expect_rec(5'd14, 5'd3, 5'd0, 32'h114, 16'h0055, 32'h14, 1'b0, 32'h77, 32'd0);
        tick();

        // Flush while EX is stalled: both the ID/EX entry and the decode instruction die
        present(5'd15, 5'd5, 5'd7, 32'h118, 16'h0066, 32'h18, 1'b0, 1'b1, 1'b1);
        tick();
        ready_e = 1'b0;
        flush_e = 1'b1;
        present(5'd20, 5'd5, 5'd0, 32'h11C, 16'h0077, 32'h1C, 1'b0, 1'b1, 1'b0);
        #1;
        chk("flush_ready_d", {31'b0, ready_d}, 32'd1);
        tick();
        flush_e = 1'b0;
        ready_e = 1'b1;
        valid_d = 1'b0;
        chk("flush_valid_e", {31'b0, valid_e}, 32'd0);
        chk("flush_bubble_cnt", {30'b0, bubble_cnt}, 32'd2);

        // Hold refresh: x9 written during a 3-cycle stall
        present(5'd16, 5'd9, 5'd5, 32'h120, 16'h0088, 32'h24, 1'b0, 1'b1, 1'b1);
        expect_rec(5'd16, 5'd9, 5'd5, 32'h120, 16'h0088, 32'h24, 1'b0, 32'h55, 32'h1234);
        tick();
        ready_e = 1'b0;
        present(5'd17, 5'd9, 5'd0, 32'h124, 16'h0099, 32'h28, 1'b0, 1'b1, 1'b0);
        #1;
        chk("hold_ready_d", {31'b0, ready_d}, 32'd0);
        tick();
        wb(1'b1, 5'd9, 32'h55);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        chk("hold_r1_refresh", r1_e, 32'h55);
        tick();
        chk("hold_pc_e", pc_e, 32'h120);
        ready_e = 1'b1;
        expect_rec(5'd17, 5'd9, 5'd0, 32'h124, 16'h0099, 32'h28, 1'b0, 32'h55, 32'd0);
        tick();
        valid_d = 1'b0;
        tick();

        // Saturation: five more load-use bubbles on a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            present(5'd4, 5'd0, 5'd0, 32'h200 + 32'(i * 8), 16'h0101, 32'd0, 1'b1, 1'b0, 1'b0);
            expect_rec(5'd4, 5'd0, 5'd0, 32'h200 + 32'(i * 8), 16'h0101, 32'd0, 1'b1, 32'd0, 32'd0);
            tick();
            if (i % 2 == 0)
                present(5'd18, 5'd4, 5'd0, 32'h204, 16'h0011, 32'd0, 1'b0, 1'b1, 1'b0);
            else
                present(5'd18, 5'd0, 5'd4, 32'h204, 16'h0011, 32'd0, 1'b0, 1'b0, 1'b1);
            tick();
            chk($sformatf("sat_bubble_cnt_%0d", i), {30'b0, bubble_cnt}, 32'd3);
            chk($sformatf("sat_valid_e_%0d", i), {31'b0, valid_e}, 32'd0);
        end

        // Reset in the middle of a hold
        present(5'd19, 5'd5, 5'd7, 32'h300, 16'hBEEF, 32'h30, 1'b1, 1'b1, 1'b1);
        tick();
        ready_e = 1'b0;
        valid_d = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_hold_valid_e", {31'b0, valid_e}, 32'd0);
        chk("rst_hold_pc_e", pc_e, 32'd0);
        chk("rst_hold_ctrl_e", {16'b0, ctrl_e}, 32'd0);
        chk("rst_hold_rd_e", {27'b0, rd_e}, 32'd0);
        chk("rst_hold_load_e", {31'b0, is_load_e}, 32'd0);
        chk("rst_hold_bubble_cnt", {30'b0, bubble_cnt}, 32'd0);

        // Register file was cleared by reset
        ready_e = 1'b1;
        present(5'd21, 5'd5, 5'd7, 32'h400, 16'h0001, 32'h40, 1'b0, 1'b1, 1'b1);
        expect_rec(5'd21, 5'd5, 5'd7, 32'h400, 16'h0001, 32'h40, 1'b0, 32'd0, 32'd0);
        tick();
        valid_d = 1'b0;
        tick();
        tick();

        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
